poci_uart: RTL and testbench
============================

// Module: poci_uart
// PURPOSE
//  POCI responder that drives the board UART pins (UART_TXD/UART_RXD), 8N1 framing, programmable baud.
//  Counterpart to the HEX/LED/KEY slaves: the core reads received bytes and writes bytes to transmit.
//  Sits on a free poci_bus slave port behind hasti_to_poci_bridge, all logic in the pclk domain.
// PARAMETERS
//  CLK_HZ      20_000_000  pclk frequency; sets reset divisor
//  BAUD        115_200     reset baud; DIV_RESET = CLK_HZ/BAUD (173), truncated
//  RX_DEPTH    4           RX FIFO entries, power of two, >= 2
// PORTS
//  pclk      in   1       system clock
//  presetn   in   1       synchronous reset, active low
//  bus       if   if_poci slave modport: paddr, psel, penable, pwrite, pwdata, prdata, pready, pslverr
//  uart_txd  out  1       serial out, idle high
//  uart_rxd  in   1       serial in, asynchronous, idle high
// BEHAVIOUR
//  Reset (presetn=0 at a pclk edge): uart_txd=1, prdata=0, pready=1, pslverr=0, FIFO empty,
//   flags clear, DIVISOR=DIV_RESET, TX/RX FSMs IDLE. Reset mid-frame aborts; no partial byte kept.
//  Bus: zero wait state, pready=1 always. Access = psel&penable; side effects exactly once, in that cycle.
//   prdata valid in the access cycle (comb from regs), 0 when not selected. Decode paddr[3:2]; offset 0xC reads 0, writes ignored.
//  0x0 DATA  W: [7:0] into TX holding reg; if holding reg full -> pslverr=1, byte dropped.
//            R: [7:0] FIFO head, [31]=empty; pops when non-empty. Empty read -> 0x8000_0000, no pop.
//  0x4 STAT  R: [0] tx_full(holding) [1] tx_busy(shifter) [2] rx_valid [3] rx_overrun [4] rx_frame_err.
//            W: write-1-to-clear [3],[4]; other bits ignored.
//  0x8 DIV   R/W [15:0] clocks per bit; writes of 0 or 1 stored as 2. Takes effect at next frame start.
//  TX FSM: IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE; each bit exactly DIV pclk cycles.
//   Holding reg loads shifter the cycle after IDLE sees it full; back-to-back bytes with no idle gap.
//   DATA write in same cycle as holding->shifter transfer: accepted (holding frees that cycle), no pslverr.
//  RX: 2-flop synchronizer, then FSM IDLE -> START -> DATA(8) -> STOP -> IDLE.
//   Falling edge in IDLE starts; sample at DIV/2 (floor); start sample high -> IDLE (glitch reject).
//   Bits sampled every DIV cycles after mid-start. Stop sample 0 -> rx_frame_err=1, byte discarded.
//   Byte push on stop sample; FIFO full -> rx_overrun=1, byte dropped, FIFO unchanged.
//   Push and pop same cycle with FIFO full: pop first, push succeeds, no overrun.
//   Pointers wrap mod RX_DEPTH; count width $clog2(RX_DEPTH)+1.
//  Bit counters: 16-bit, reload DIV-1 and count to 0; no wraparound beyond 16 bits.
//  Sticky flags: set has priority over W1C clear in the same cycle.
// STRUCTURE
//  pk_poci: add POCI_UART_DATA/STAT/DIV offsets, STAT bit index localparams, uart_state_t enum
//   {IDLE,START,DATA,STOP} shared by both FSMs, and the poci_uart base address.
//  One sub-module: poci_uart_rx (synchronizer + RX FSM; outputs rx_byte, rx_strobe, rx_ferr).
//  TX FSM, FIFO and register file stay in poci_uart.
// TESTING (DIV=4 for speed unless stated)
//  Reset: uart_txd=1, read STAT -> 0x0, read DIV -> 173, read DATA -> 0x8000_0000.
//  TX: write DATA=0xA5 -> txd low 4 clk, bits 1,0,1,0,0,1,0,1 x4 clk each, high 4 clk; STAT[1] then 0.
//  TX back-to-back: write 0x55 then 0x0F at once -> 2nd ok, 3rd gets pslverr=1; 20 contiguous bit times.
//  RX: drive 0x3C frame -> STAT[2]=1, DATA read -> 0x3C, next read -> 0x8000_0000.
//  RX overrun/frame: 5 bytes with DEPTH 4 -> STAT[3]=1, first 4 read in order; stop bit 0 -> STAT[4]=1;
//   write STAT=0x18 -> flags clear.
//  Glitch and reset: 1-clk low pulse on rxd -> no byte; presetn low mid-TX -> txd=1 next cycle.

Source files
------------

// File: rtl/poci_uart_pkg.sv
// Shared definitions for the POCI UART responder: register map, STAT bit
// positions, the state type used by both serial FSMs and the divisor clamp.
package poci_uart_pkg;

   localparam logic [31:0] POCI_UART_BASE = 32'h4000_3000;

   localparam logic [3:0] POCI_UART_DATA = 4'h0;
   localparam logic [3:0] POCI_UART_STAT = 4'h4;
   localparam logic [3:0] POCI_UART_DIV  = 4'h8;

   localparam int unsigned STAT_TX_FULL    = 0;
   localparam int unsigned STAT_TX_BUSY    = 1;
   localparam int unsigned STAT_RX_VALID   = 2;
   localparam int unsigned STAT_RX_OVERRUN = 3;
   localparam int unsigned STAT_RX_FERR    = 4;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   // A bit period shorter than two clocks cannot be mid-sampled.
   function automatic logic [15:0] clamp_div(input logic [15:0] v);
      return (v < 16'd2) ? 16'd2 : v;
   endfunction

endpackage

// File: rtl/poci_uart_rx.sv
// UART receiver: synchronises the asynchronous serial input and recovers
// 8N1 frames, reporting each good byte or framing error as a one-cycle pulse.
module poci_uart_rx
   import poci_uart_pkg::*;
(
   input  logic        pclk,
   input  logic        presetn,
   input  logic [15:0] div,
   input  logic        rxd,
   output logic [7:0]  rx_byte,
   output logic        rx_strobe,
   output logic        rx_ferr
);

   logic        sync1, sync2, sync3;
   uart_state_t state;
   logic [15:0] cnt;
   logic [15:0] cur_div;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;

   // Two-flop synchroniser plus one more stage for falling-edge detection.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         sync3 <= 1'b1;
      end else begin
         sync1 <= rxd;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // Frame FSM: mid-start check at DIV/2, then one sample every DIV cycles.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state     <= IDLE;
         cnt       <= '0;
         cur_div   <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         rx_strobe <= 1'b0;
         rx_ferr   <= 1'b0;
      end else begin
         rx_strobe <= 1'b0;
         rx_ferr   <= 1'b0;
         case (state)
            IDLE: begin
               if (sync3 && !sync2) begin
                  state   <= START;
                  cur_div <= div;
                  cnt     <= (div >> 1) - 16'd1;
               end
            end
            START: begin
               if (cnt == '0) begin
                  if (sync2) begin
                     state <= IDLE;
                  end else begin
                     state   <= DATA;
                     cnt     <= cur_div - 16'd1;
                     bit_idx <= '0;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  shift   <= {sync2, shift[7:1]};
                  cnt     <= cur_div - 16'd1;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            STOP: begin
               if (cnt == '0) begin
                  if (sync2) rx_strobe <= 1'b1;
                  else       rx_ferr   <= 1'b1;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rx_byte = shift;

endmodule

// File: rtl/poci_uart.sv
// POCI UART responder: register file, TX holding register and shifter,
// RX FIFO and sticky status flags, all in the pclk domain.
module poci_uart
   import poci_uart_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 20_000_000,
   parameter int unsigned BAUD     = 115_200,
   parameter int unsigned RX_DEPTH = 4
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic [31:0] paddr,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   output logic        uart_txd,
   input  logic        uart_rxd
);

   localparam int unsigned AW = $clog2(RX_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD);
   localparam logic [CW-1:0] FIFO_FULL = CW'(RX_DEPTH);

   logic [15:0]   div_reg;
   logic          rx_ovr_flag, rx_ferr_flag;

   uart_state_t   tx_state;
   logic [15:0]   tx_cnt, tx_div;
   logic [2:0]    tx_idx;
   logic [7:0]    tx_shift, tx_hold;
   logic          tx_full;

   logic [7:0]    rx_mem [RX_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] rx_count;

   logic [7:0]    rx_byte;
   logic          rx_strobe, rx_ferr;

   logic [3:0]    reg_off;
   logic          access, data_wr, stat_wr, div_wr, tx_load, tx_accept;
   logic          rx_pop, rx_push, rx_drop;
   logic          unused_bits;

   poci_uart_rx u_rx (
      .pclk      (pclk),
      .presetn   (presetn),
      .div       (div_reg),
      .rxd       (uart_rxd),
      .rx_byte   (rx_byte),
      .rx_strobe (rx_strobe),
      .rx_ferr   (rx_ferr)
   );

   assign reg_off = {paddr[3:2], 2'b00};
   assign access  = psel & penable;
   assign data_wr = access & pwrite & (reg_off == POCI_UART_DATA);
   assign stat_wr = access & pwrite & (reg_off == POCI_UART_STAT);
   assign div_wr  = access & pwrite & (reg_off == POCI_UART_DIV);

   // The holding register frees in the same cycle it loads the shifter, so a
   // write landing on that cycle is accepted rather than refused.
   assign tx_load   = tx_full & ((tx_state == IDLE) | ((tx_state == STOP) & (tx_cnt == '0)));
   assign tx_accept = data_wr & (~tx_full | tx_load);
   assign pslverr   = data_wr & tx_full & ~tx_load;
   assign pready    = 1'b1;

   assign rx_pop  = access & ~pwrite & (reg_off == POCI_UART_DATA) & (rx_count != '0);
   assign rx_push = rx_strobe & ((rx_count != FIFO_FULL) | rx_pop);
   assign rx_drop = rx_strobe & (rx_count == FIFO_FULL) & ~rx_pop;

   assign unused_bits = ^{paddr[31:4], paddr[1:0], pwdata[31:16]};

   // Read mux, combinational from registers, zero when not selected.
   always_comb begin
      prdata = '0;
      if (psel) begin
         case (reg_off)
            POCI_UART_DATA: prdata = (rx_count == '0) ? 32'h8000_0000 : {24'h0, rx_mem[rd_ptr]};
            POCI_UART_STAT: begin
               prdata[STAT_TX_FULL]    = tx_full;
               prdata[STAT_TX_BUSY]    = (tx_state != IDLE);
               prdata[STAT_RX_VALID]   = (rx_count != '0);
               prdata[STAT_RX_OVERRUN] = rx_ovr_flag;
               prdata[STAT_RX_FERR]    = rx_ferr_flag;
            end
            POCI_UART_DIV:  prdata = {16'h0, div_reg};
            default:        prdata = '0;
         endcase
      end
   end

   // Divisor and sticky flags; a set event overrides a same-cycle W1C.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         div_reg      <= DIV_RESET;
         rx_ovr_flag  <= 1'b0;
         rx_ferr_flag <= 1'b0;
      end else begin
         if (div_wr) div_reg <= clamp_div(pwdata[15:0]);
         if (stat_wr && pwdata[STAT_RX_OVERRUN]) rx_ovr_flag <= 1'b0;
         if (rx_drop) rx_ovr_flag <= 1'b1;
         if (stat_wr && pwdata[STAT_RX_FERR]) rx_ferr_flag <= 1'b0;
         if (rx_ferr) rx_ferr_flag <= 1'b1;
      end
   end

   // TX holding register and frame FSM; a full holding register at the end
   // of STOP chains straight into the next START with no idle gap.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         tx_state <= IDLE;
         uart_txd <= 1'b1;
         tx_cnt   <= '0;
         tx_div   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
         tx_hold  <= '0;
         tx_full  <= 1'b0;
      end else begin
         if (tx_accept) begin
            tx_hold <= pwdata[7:0];
            tx_full <= 1'b1;
         end else if (tx_load) begin
            tx_full <= 1'b0;
         end
         if (tx_load) begin
            tx_state <= START;
            uart_txd <= 1'b0;
            tx_shift <= tx_hold;
            tx_div   <= div_reg;
            tx_cnt   <= div_reg - 16'd1;
         end else begin
            case (tx_state)
               IDLE: uart_txd <= 1'b1;
               START: begin
                  if (tx_cnt == '0) begin
                     tx_state <= DATA;
                     uart_txd <= tx_shift[0];
                     tx_idx   <= '0;
                     tx_cnt   <= tx_div - 16'd1;
                  end else begin
                     tx_cnt <= tx_cnt - 16'd1;
                  end
               end
               DATA: begin
                  if (tx_cnt == '0) begin
                     tx_cnt <= tx_div - 16'd1;
                     tx_idx <= tx_idx + 3'd1;
                     if (tx_idx == 3'd7) begin
                        tx_state <= STOP;
                        uart_txd <= 1'b1;
                     end else begin
                        uart_txd <= tx_shift[1];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                     end
                  end else begin
                     tx_cnt <= tx_cnt - 16'd1;
                  end
               end
               STOP: begin
                  if (tx_cnt == '0) tx_state <= IDLE;
                  else              tx_cnt   <= tx_cnt - 16'd1;
               end
               default: tx_state <= IDLE;
            endcase
         end
      end
   end

   // RX FIFO pointers and occupancy; pointers wrap naturally at RX_DEPTH.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rx_count <= '0;
      end else begin
         if (rx_push) wr_ptr <= wr_ptr + AW'(1);
         if (rx_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + CW'(1);
            2'b01:   rx_count <= rx_count - CW'(1);
            default: rx_count <= rx_count;
         endcase
      end
   end

   // RX FIFO storage.
   always_ff @(posedge pclk) begin
      if (rx_push) rx_mem[wr_ptr] <= rx_byte;
   end

endmodule

// File: tb/tb_poci_uart.sv
// Self-checking bench for poci_uart: bus register checks, TX waveform checks
// against frames built from the byte values, RX checked against a queue model.
module tb_poci_uart;

   localparam int RXD = 4;

   logic        pclk, presetn;
   logic [31:0] paddr, pwdata, prdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic        uart_txd, uart_rxd;

   int n_checks = 0;
   int n_fail   = 0;

   logic       log_en = 1'b0;
   logic       tx_log[$];
   logic [7:0] rx_q[$];
   logic       m_ovr = 1'b0;
   logic       m_ferr = 1'b0;

   poci_uart #(.CLK_HZ(20_000_000), .BAUD(115_200), .RX_DEPTH(RXD)) dut (
      .pclk     (pclk),
      .presetn  (presetn),
      .paddr    (paddr),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .pwdata   (pwdata),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr),
      .uart_txd (uart_txd),
      .uart_rxd (uart_rxd)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   always @(negedge pclk) if (log_en) tx_log.push_back(uart_txd);

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err);
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {28'h0, addr}; pwdata = wdata;
      @(negedge pclk);
      penable = 1'b1;
      #1;
      rdata = prdata;
      err   = pslverr;
      @(posedge pclk);
      #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic bus_write(input logic [3:0] addr, input logic [31:0] wdata, output logic err);
      logic [31:0] d;
      bus_xfer(1'b1, addr, wdata, d, err);
   endtask

   task automatic bus_read(input logic [3:0] addr, output logic [31:0] rdata);
      logic e;
      bus_xfer(1'b0, addr, 32'h0, rdata, e);
   endtask

   task automatic check_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(addr, d);
      check_eq(tag, d, exp);
   endtask

   task automatic set_div(input logic [15:0] v);
      logic e;
      bus_write(4'h8, {16'h0, v}, e);
   endtask

   // Reference TX waveform: start 0, data LSB first, stop 1, each div samples.
   task automatic check_tx_log(input string tag, input logic [7:0] bytes[$], input int div);
      int start = -1;
      logic [31:0] got, exp;
      logic eb;
      int idx;
      for (int i = 0; i < tx_log.size(); i++) begin
         if (tx_log[i] == 1'b0) begin
            start = i;
            break;
         end
      end
      check_eq({tag, " start seen"}, 32'(start >= 0), 32'd1);
      if (start < 0) return;
      for (int k = 0; k < bytes.size(); k++) begin
         for (int j = 0; j < 10; j++) begin
            eb = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : bytes[k][j-1];
            got = '0; exp = '0;
            for (int c = 0; c < div; c++) begin
               idx = start + (k * 10 + j) * div + c;
               got[c] = (idx < tx_log.size()) ? tx_log[idx] : 1'bx;
               exp[c] = eb;
            end
            check_eq($sformatf("%s byte%0d bit%0d", tag, k, j), got, exp);
         end
      end
      got = '0; exp = '0;
      for (int c = 0; c < 2 * div; c++) begin
         idx = start + bytes.size() * 10 * div + c;
         got[c] = (idx < tx_log.size()) ? tx_log[idx] : 1'bx;
         exp[c] = 1'b1;
      end
      check_eq({tag, " trailing idle"}, got, exp);
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input int div);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rxd = bits[i];
         repeat (div) @(negedge pclk);
      end
      uart_rxd = 1'b1;
      repeat (2 * div) @(negedge pclk);
      if (!stop_bit)              m_ferr = 1'b1;
      else if (rx_q.size() == RXD) m_ovr = 1'b1;
      else                        rx_q.push_back(b);
   endtask

   task automatic check_stat(input string tag);
      logic [31:0] exp;
      exp = {27'h0, m_ferr, m_ovr, rx_q.size() != 0, 2'b00};
      check_read(tag, 4'h4, exp);
   endtask

   task automatic check_data(input string tag);
      logic [31:0] exp;
      if (rx_q.size() == 0) exp = 32'h8000_0000;
      else                  exp = {24'h0, rx_q.pop_front()};
      check_read(tag, 4'h0, exp);
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      logic [7:0]  bq[$];
      logic [7:0]  b;
      logic        seen;
      int          dv;

      presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; uart_rxd = 1'b1;
      repeat (3) @(negedge pclk);
      check_eq("reset txd", {31'h0, uart_txd}, 32'd1);
      check_eq("reset pready", {31'h0, pready}, 32'd1);
      presetn = 1'b1;
      check_read("reset STAT", 4'h4, 32'h0);
      check_read("reset DIV", 4'h8, 32'd173);
      check_read("reset DATA", 4'h0, 32'h8000_0000);
      check_read("offset C", 4'hC, 32'h0);

      // Divisor clamp and ignored offset.
      set_div(16'd0);  check_read("DIV write 0", 4'h8, 32'd2);
      set_div(16'd1);  check_read("DIV write 1", 4'h8, 32'd2);
      bus_write(4'hC, 32'hFFFF_FFFF, e);
      check_read("offset C after write", 4'hC, 32'h0);
      set_div(16'd4);  check_read("DIV write 4", 4'h8, 32'd4);

      // Single byte 0xA5.
      tx_log.delete(); log_en = 1'b1;
      bus_write(4'h0, 32'hA5, e);
      check_eq("A5 pslverr", {31'h0, e}, 32'd0);
      check_read("STAT mid frame", 4'h4, 32'h2);
      repeat (12 * 4) @(negedge pclk);
      check_read("STAT after frame", 4'h4, 32'h0);
      bq = '{8'hA5};
      check_tx_log("txA5", bq, 4);

      // Back-to-back bytes, third write refused.
      tx_log.delete();
      bus_write(4'h0, 32'h55, e); check_eq("b2b 1st pslverr", {31'h0, e}, 32'd0);
      bus_write(4'h0, 32'h0F, e); check_eq("b2b 2nd pslverr", {31'h0, e}, 32'd0);
      bus_write(4'h0, 32'hC3, e); check_eq("b2b 3rd pslverr", {31'h0, e}, 32'd1);
      repeat (24 * 4) @(negedge pclk);
      bq = '{8'h55, 8'h0F};
      check_tx_log("txb2b", bq, 4);

      // Random TX bytes at random divisors.
      for (int it = 0; it < 4; it++) begin
         dv = $urandom_range(3, 8);
         b  = 8'($urandom);
         set_div(16'(dv));
         check_read($sformatf("rand DIV %0d", it), 4'h8, 32'(dv));
         tx_log.delete();
         bus_write(4'h0, {24'h0, b}, e);
         repeat (12 * dv + 8) @(negedge pclk);
         bq = '{b};
         check_tx_log($sformatf("txrand%0d", it), bq, dv);
      end
      log_en = 1'b0;

      // RX single byte.
      set_div(16'd4);
      rx_frame(8'h3C, 1'b1, 4);
      check_stat("rx 3C STAT");
      check_data("rx 3C DATA");
      check_data("rx empty DATA");

      // Overrun, then frame error, then W1C.
      for (int i = 0; i < 5; i++) rx_frame(8'($urandom), 1'b1, 4);
      check_stat("overrun STAT");
      for (int i = 0; i < 4; i++) check_data($sformatf("overrun DATA%0d", i));
      check_data("overrun empty");
      rx_frame(8'($urandom), 1'b0, 4);
      check_stat("frame err STAT");
      bus_write(4'h4, 32'h07, e);
      check_stat("W1C other bits");
      bus_write(4'h4, 32'h18, e);
      m_ovr = 1'b0; m_ferr = 1'b0;
      check_stat("W1C cleared");

      // Random RX traffic.
      for (int it = 0; it < 6; it++) begin
         dv = $urandom_range(3, 8);
         set_div(16'(dv));
         rx_frame(8'($urandom), ($urandom_range(0, 4) != 0), dv);
         check_stat($sformatf("rxrand STAT%0d", it));
         check_data($sformatf("rxrand DATA%0d", it));
         bus_write(4'h4, 32'h18, e);
         m_ovr = 1'b0; m_ferr = 1'b0;
      end

      // One-clock glitch is rejected.
      set_div(16'd4);
      @(negedge pclk); uart_rxd = 1'b0;
      @(negedge pclk); uart_rxd = 1'b1;
      repeat (60) @(negedge pclk);
      check_stat("glitch STAT");
      check_data("glitch DATA");

      // Reset mid-TX returns the line high on the next cycle.
      bus_write(4'h0, 32'h00, e);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge pclk);
         if (!uart_txd) seen = 1'b1;
      end
      check_eq("rst midTX low seen", {31'h0, seen}, 32'd1);
      presetn = 1'b0;
      @(negedge pclk);
      check_eq("rst midTX txd", {31'h0, uart_txd}, 32'd1);
      presetn = 1'b1;
      check_read("rst midTX STAT", 4'h4, 32'h0);
      check_read("rst midTX DIV", 4'h8, 32'd173);

      // Reset mid-RX leaves no partial byte.
      set_div(16'd4);
      uart_rxd = 1'b0;
      repeat (4 * 4) @(negedge pclk);
      presetn = 1'b0;
      @(negedge pclk);
      uart_rxd = 1'b1;
      presetn = 1'b1;
      repeat (200) @(negedge pclk);
      check_stat("rst midRX STAT");
      check_data("rst midRX DATA");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
